riscv_writeback_stage: RTL and testbench

Writeback stage that merges ALU results and load-return data into the single write port of the general-purpose register file. ALU results are queued in a small FIFO. Load returns cannot be stalled, so they take priority on the port. The stage drives registered `we`/`wr_addr`/`wr_data` to the register file and exposes the same registered values as a forwarding source.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_writeback_stage_if.sv | 38 +++
 rtl/riscv_wb_fifo.sv | 47 ++++
 rtl/riscv_writeback_stage.sv | 111 +++++++++++
 tb/tb_riscv_writeback_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V writeback stage and its FIFO.
package riscv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   // Load funct3 encodings as they arrive from the LSU.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // One pending register-file write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/riscv_writeback_stage_if.sv
// Bus between the execute/load paths, the writeback stage and the register file.
// Handshake: an ALU result transfers on a rising clk edge where ex_valid and
// ex_ready are both high; ex_valid must not depend on ex_ready. mem_valid has no
// ready and is consumed on every edge where it is high. rf_we marks one write.
interface riscv_writeback_stage_if;
   import riscv_pkg::*;

   logic                  ex_valid;
   logic                  ex_ready;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [XLEN-1:0]       ex_data;

   logic                  mem_valid;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [XLEN-1:0]       mem_data;
   logic [2:0]            mem_funct3;
   logic [1:0]            mem_offset;

   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_wr_addr;
   logic [XLEN-1:0]       rf_wr_data;
   logic                  busy;

   // Producer side (execute unit, LSU) that also observes the register-file port.
   modport master (
      output ex_valid, ex_rd, ex_data,
      output mem_valid, mem_rd, mem_data, mem_funct3, mem_offset,
      input  ex_ready, rf_we, rf_wr_addr, rf_wr_data, busy
   );

   // The writeback stage itself.
   modport slave (
      input  ex_valid, ex_rd, ex_data,
      input  mem_valid, mem_rd, mem_data, mem_funct3, mem_offset,
      output ex_ready, rf_we, rf_wr_addr, rf_wr_data, busy
   );

endinterface

// File: rtl/riscv_wb_fifo.sv
// Small FIFO of pending ALU writebacks. Pointers carry one extra wrap bit so
// full and empty are distinguished without a counter. DEPTH must be a power of
// two and at least 2. Only the pointers are reset; stored data is don't-care
// while the FIFO is empty. The caller never pushes when full or pops when empty.
module riscv_wb_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   wb_entry_t   mem_q [DEPTH];

   // Pointer advance; wrap happens naturally on the extra MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Entry storage, written at the tail.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/riscv_writeback_stage.sv
// Writeback stage: merges queued ALU results and unstallable load returns onto
// the single register-file write port. Loads always win the port; ALU results
// wait in riscv_wb_fifo. The registered rf_* outputs double as a forwarding source.
// Build option: define WB_LOAD_EXT_EN to sign/zero-extend loads here; without it
// mem_data is written unchanged and mem_funct3/mem_offset are ignored.
module riscv_writeback_stage
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   riscv_writeback_stage_if.slave bus
);

   wb_entry_t             fifo_din;
   wb_entry_t             fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  ex_fire;
   logic                  push;
   logic                  pop;
   logic                  mem_take;
   logic [XLEN-1:0]       load_word;

   logic                  rf_we_q;
   logic [REG_ADDR_W-1:0] rf_addr_q;
   logic [XLEN-1:0]       rf_data_q;

`ifdef WB_LOAD_EXT_EN
   // Select the addressed byte/half and extend according to funct3.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      funct3,
                                                input logic [1:0]      off,
                                                input logic [XLEN-1:0] word);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      // Bit 0 of the offset plays no part for halfwords.
      h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   r = {{24{b[7]}}, b};
         F3_LH:   r = {{16{h[15]}}, h};
         F3_LBU:  r = {24'h0, b};
         F3_LHU:  r = {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign load_word = load_ext(bus.mem_funct3, bus.mem_offset, bus.mem_data);
`else
   // The LSU already extended the word; load type and offset are informational.
   logic unused_load_ctl;
   assign unused_load_ctl = ^{bus.mem_funct3, bus.mem_offset};
   assign load_word       = bus.mem_data;
`endif

   // ex_ready looks only at registered FIFO state, never at a same-cycle pop.
   assign bus.ex_ready = !fifo_full;
   assign ex_fire      = bus.ex_valid && !fifo_full;
   // Writes to x0 complete the handshake but are discarded.
   assign push         = ex_fire && (bus.ex_rd != '0);
   // A load to x0 is dropped and does not claim the port.
   assign mem_take     = bus.mem_valid && (bus.mem_rd != '0);
   assign pop          = !mem_take && !fifo_empty;
   assign fifo_din     = '{rd: bus.ex_rd, data: bus.ex_data};

   riscv_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Port arbitration: load first, then FIFO head; idle keeps addr/data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else if (mem_take) begin
         rf_we_q   <= 1'b1;
         rf_addr_q <= bus.mem_rd;
         rf_data_q <= load_word;
      end else if (pop) begin
         rf_we_q   <= 1'b1;
         rf_addr_q <= fifo_dout.rd;
         rf_data_q <= fifo_dout.data;
      end else begin
         rf_we_q   <= 1'b0;
      end
   end

   assign bus.rf_we      = rf_we_q;
   assign bus.rf_wr_addr = rf_addr_q;
   assign bus.rf_wr_data = rf_data_q;
   assign bus.busy       = !fifo_empty || rf_we_q;

endmodule

// File: tb/tb_riscv_writeback_stage.sv
// Directed bench for riscv_writeback_stage (DEPTH=2). Inputs change and outputs
// are sampled on the falling edge; a scoreboard checks every committed write
// against an expected queue. Load expectations follow WB_LOAD_EXT_EN.
module tb_riscv_writeback_stage;
   import riscv_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [36:0] exp_q [$];

   riscv_writeback_stage_if wb ();

   riscv_writeback_stage #(
      .DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (wb)
   );

   localparam logic [31:0] LD_WORD = 32'h80FF7F01;
`ifdef WB_LOAD_EXT_EN
   localparam logic [31:0] EXP_LB3  = 32'hFFFFFF80;
   localparam logic [31:0] EXP_LBU3 = 32'h00000080;
   localparam logic [31:0] EXP_LHU2 = 32'h000080FF;
   localparam logic [31:0] EXP_LH0  = 32'h00007F01;
   localparam logic [31:0] EXP_LH3  = 32'hFFFF80FF;
   localparam logic [31:0] EXP_LB0  = 32'h00000001;
`else
   localparam logic [31:0] EXP_LB3  = LD_WORD;
   localparam logic [31:0] EXP_LBU3 = LD_WORD;
   localparam logic [31:0] EXP_LHU2 = LD_WORD;
   localparam logic [31:0] EXP_LH0  = LD_WORD;
   localparam logic [31:0] EXP_LH3  = LD_WORD;
   localparam logic [31:0] EXP_LB0  = LD_WORD;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && wb.rf_we) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_commit", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("sb_addr", 32'(wb.rf_wr_addr), 32'(e[36:32]));
            check("sb_data", wb.rf_wr_data, e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      wb.ex_valid   = 1'b0;
      wb.ex_rd      = '0;
      wb.ex_data    = '0;
      wb.mem_valid  = 1'b0;
      wb.mem_rd     = '0;
      wb.mem_data   = '0;
      wb.mem_funct3 = F3_LW;
      wb.mem_offset = 2'd0;
   endtask

   task automatic drive_load(input logic [4:0] rd, input logic [31:0] data,
                             input logic [2:0] f3, input logic [1:0] off);
      wb.mem_valid  = 1'b1;
      wb.mem_rd     = rd;
      wb.mem_data   = data;
      wb.mem_funct3 = f3;
      wb.mem_offset = off;
   endtask

   // One load of LD_WORD, checked one edge later.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] exp);
      exp_q.push_back({5'd3, exp});
      drive_load(5'd3, LD_WORD, f3, off);
      @(negedge clk);
      wb.mem_valid = 1'b0;
      check({tag, "_we"}, 32'(wb.rf_we), 32'd1);
      check(tag, wb.rf_wr_data, exp);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && wb.busy; i++) @(negedge clk);
      check(tag, 32'(wb.busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  idx;
      logic acc;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      check("rst_we",    32'(wb.rf_we),      32'd0);
      check("rst_addr",  32'(wb.rf_wr_addr), 32'd0);
      check("rst_data",  wb.rf_wr_data,      32'd0);
      check("rst_ready", 32'(wb.ex_ready),   32'd1);
      check("rst_busy",  32'(wb.busy),       32'd0);
      rst = 1'b0;

      // Single ALU result: write enable exactly one cycle, two edges after acceptance.
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      wb.ex_valid = 1'b1;
      wb.ex_rd    = 5'd5;
      wb.ex_data  = 32'hDEADBEEF;
      @(negedge clk);
      wb.ex_valid = 1'b0;
      check("alu_we_early", 32'(wb.rf_we), 32'd0);
      check("alu_busy",     32'(wb.busy),  32'd1);
      @(negedge clk);
      check("alu_we",   32'(wb.rf_we),      32'd1);
      check("alu_addr", 32'(wb.rf_wr_addr), 32'd5);
      check("alu_data", wb.rf_wr_data,      32'hDEADBEEF);
      @(negedge clk);
      check("alu_we_once", 32'(wb.rf_we), 32'd0);
      check("alu_idle",    32'(wb.busy),  32'd0);

      // Load extension, back-to-back loads.
      do_load("lb_off3",  F3_LB,  2'd3, EXP_LB3);
      do_load("lbu_off3", F3_LBU, 2'd3, EXP_LBU3);
      do_load("lhu_off2", F3_LHU, 2'd2, EXP_LHU2);
      do_load("lh_off0",  F3_LH,  2'd0, EXP_LH0);
      do_load("lh_off3",  F3_LH,  2'd3, EXP_LH3);
      do_load("lb_off0",  F3_LB,  2'd0, EXP_LB0);
      do_load("lw_off0",  F3_LW,  2'd0, LD_WORD);
      do_load("f3_other", 3'b011, 2'd1, LD_WORD);
      @(negedge clk);
      check("load_we_off", 32'(wb.rf_we), 32'd0);

      // Loads held four cycles starve the FIFO; ALU results follow in order.
      for (int i = 0; i < 4; i++) exp_q.push_back({5'(20 + i), 32'hA0000000 + 32'(i)});
      for (int i = 0; i < 4; i++) exp_q.push_back({5'(10 + i), 32'hB0000000 + 32'(i)});
      idx = 0;
      for (int cyc = 0; cyc < 40 && (idx < 4 || cyc < 4); cyc++) begin
         if (cyc < 4) drive_load(5'(20 + cyc), 32'hA0000000 + 32'(cyc), F3_LW, 2'd0);
         else wb.mem_valid = 1'b0;
         wb.ex_valid = (idx < 4);
         wb.ex_rd    = 5'(10 + idx);
         wb.ex_data  = 32'hB0000000 + 32'(idx);
         acc = wb.ex_valid && wb.ex_ready;
         @(negedge clk);
         if (acc) idx++;
         if (cyc < 4) begin
            check("starve_load_we",   32'(wb.rf_we),      32'd1);
            check("starve_load_addr", 32'(wb.rf_wr_addr), 32'(20 + cyc));
         end
         if (cyc == 0) check("starve_ready_one", 32'(wb.ex_ready), 32'd1);
         if (cyc >= 1 && cyc <= 3) check("starve_ready_full", 32'(wb.ex_ready), 32'd0);
      end
      idle();
      check("starve_accepted", 32'(idx), 32'd4);
      drain("starve_drain");

      // Eight streamed results: push and pop together at occupancy 1, pointers wrap.
      for (int i = 1; i <= 8; i++) exp_q.push_back({5'(i), 32'hC0000000 + 32'(i * 32'h111)});
      idx = 1;
      for (int cyc = 0; cyc < 40 && idx <= 8; cyc++) begin
         wb.ex_valid = 1'b1;
         wb.ex_rd    = 5'(idx);
         wb.ex_data  = 32'hC0000000 + 32'(idx * 32'h111);
         acc = wb.ex_valid && wb.ex_ready;
         @(negedge clk);
         if (acc) idx++;
         check("stream_ready", 32'(wb.ex_ready), 32'd1);
         if (cyc == 0) check("stream_we0", 32'(wb.rf_we), 32'd0);
         if (cyc == 1) begin
            check("stream_we1",   32'(wb.rf_we),      32'd1);
            check("stream_addr1", 32'(wb.rf_wr_addr), 32'd1);
         end
      end
      idle();
      check("stream_accepted", 32'(idx), 32'd9);
      drain("stream_drain");

      // Writes to x0 from both paths complete but never reach the port.
      wb.ex_valid = 1'b1;
      wb.ex_rd    = 5'd0;
      wb.ex_data  = 32'h55555555;
      drive_load(5'd0, 32'h66666666, F3_LW, 2'd0);
      check("x0_ready", 32'(wb.ex_ready), 32'd1);
      @(negedge clk);
      idle();
      check("x0_we",    32'(wb.rf_we),    32'd0);
      check("x0_busy",  32'(wb.busy),     32'd0);
      check("x0_ready2", 32'(wb.ex_ready), 32'd1);
      @(negedge clk);
      check("x0_we2", 32'(wb.rf_we), 32'd0);

      // A queued result still pops while a load to x0 is presented.
      exp_q.push_back({5'd7, 32'h00000077});
      wb.ex_valid = 1'b1;
      wb.ex_rd    = 5'd7;
      wb.ex_data  = 32'h00000077;
      @(negedge clk);
      wb.ex_valid = 1'b0;
      drive_load(5'd0, 32'h00001234, F3_LW, 2'd0);
      check("x0pop_we_early", 32'(wb.rf_we), 32'd0);
      @(negedge clk);
      idle();
      check("x0pop_we",   32'(wb.rf_we),      32'd1);
      check("x0pop_addr", 32'(wb.rf_wr_addr), 32'd7);
      @(negedge clk);
      check("x0pop_idle", 32'(wb.busy), 32'd0);

      // Reset with two queued entries and a write in flight.
      exp_q.push_back({5'd24, 32'hD0000000});
      exp_q.push_back({5'd25, 32'hD0000001});
      for (int cyc = 0; cyc < 2; cyc++) begin
         drive_load(5'(24 + cyc), 32'hD0000000 + 32'(cyc), F3_LW, 2'd0);
         wb.ex_valid = 1'b1;
         wb.ex_rd    = 5'(14 + cyc);
         wb.ex_data  = 32'hE0000000 + 32'(cyc);
         @(negedge clk);
      end
      idle();
      check("prerst_we",    32'(wb.rf_we),    32'd1);
      check("prerst_ready", 32'(wb.ex_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("midrst_we",    32'(wb.rf_we),      32'd0);
      check("midrst_addr",  32'(wb.rf_wr_addr), 32'd0);
      check("midrst_data",  wb.rf_wr_data,      32'd0);
      check("midrst_busy",  32'(wb.busy),       32'd0);
      check("midrst_ready", 32'(wb.ex_ready),   32'd1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postrst_we", 32'(wb.rf_we), 32'd0);
      end
      exp_q.push_back({5'd16, 32'h16161616});
      wb.ex_valid = 1'b1;
      wb.ex_rd    = 5'd16;
      wb.ex_data  = 32'h16161616;
      @(negedge clk);
      idle();
      @(negedge clk);
      check("postrst_new_we", 32'(wb.rf_we), 32'd1);
      drain("postrst_drain");

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
